// File: rtl/md_seq.sv
// HI/LO multiply-divide sequencer: results are computed at issue, held in a shadow
// pair, and committed to HI/LO after a fixed busy interval while the pipeline stalls.
module md_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        exc_int,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        done
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic             done_q, done_d;

    // Arithmetic datapath, evaluated every cycle from the forwarded operands.
    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic        [31:0] divisor;
    logic        [31:0] abs_a, abs_b;
    logic        [31:0] uq, ur;
    logic        [31:0] sq_mag, sr_mag;
    logic        [31:0] sq, sr;
    logic               div_zero;
    logic               div_ovf;

    always_comb begin
        smul     = $signed(rs_val) * $signed(rt_val);
        umul     = {32'd0, rs_val} * {32'd0, rt_val};
        div_zero = (rt_val == 32'd0);
        div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        // Substitute divisor keeps the divider defined; zero-divide results are overridden below.
        divisor  = div_zero ? 32'd1 : rt_val;
        uq       = rs_val / divisor;
        ur       = rs_val % divisor;
        abs_a    = rs_val[31] ? (32'd0 - rs_val) : rs_val;
        abs_b    = divisor[31] ? (32'd0 - divisor) : divisor;
        sq_mag   = abs_a / abs_b;
        sr_mag   = abs_a % abs_b;
        sq       = (rs_val[31] ^ divisor[31]) ? (32'd0 - sq_mag) : sq_mag;
        sr       = rs_val[31] ? (32'd0 - sr_mag) : sr_mag;
    end

    logic is_long;
    logic accept;
    logic issue;

    always_comb begin
        is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        accept  = (state_q == ST_IDLE) && op_valid && !exc_int;
        issue   = accept && is_long;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        done_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            if (issue) begin
                state_d = ST_BUSY;
                case (op)
                    OP_MULT: begin
                        cnt_d    = MULT_LOAD;
                        tmp_hi_d = smul[63:32];
                        tmp_lo_d = smul[31:0];
                    end
                    OP_MULTU: begin
                        cnt_d    = MULT_LOAD;
                        tmp_hi_d = umul[63:32];
                        tmp_lo_d = umul[31:0];
                    end
                    OP_DIV: begin
                        cnt_d = DIV_LOAD;
                        if (div_zero) begin
                            tmp_hi_d = rs_val;
                            tmp_lo_d = 32'hFFFF_FFFF;
                        end else if (div_ovf) begin
                            tmp_hi_d = 32'd0;
                            tmp_lo_d = 32'h8000_0000;
                        end else begin
                            tmp_hi_d = sr;
                            tmp_lo_d = sq;
                        end
                    end
                    default: begin
                        cnt_d = DIV_LOAD;
                        if (div_zero) begin
                            tmp_hi_d = rs_val;
                            tmp_lo_d = 32'hFFFF_FFFF;
                        end else begin
                            tmp_hi_d = ur;
                            tmp_lo_d = uq;
                        end
                    end
                endcase
            end else if (accept && (op == OP_MTHI)) begin
                hi_d = rs_val;
            end else if (accept && (op == OP_MTLO)) begin
                lo_d = rs_val;
            end
        end else begin
            // exc_int is deliberately ignored here: an issued op always commits.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d    = tmp_hi_q;
                lo_d    = tmp_lo_q;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        busy  = (state_q == ST_BUSY);
        stall = op_valid && busy;
        hi    = hi_q;
        lo    = lo_q;
        done  = done_q;
        case (op)
            OP_MFHI: rd_data = hi_q;
            OP_MFLO: rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op_valid  in  1  E-stage holds a multiply/divide-class instruction.
REQ-006 op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
REQ-007 rs_val  in  32  forwarded rs operand.
REQ-008 rt_val  in  32  forwarded rt operand.
REQ-009 exc_int  in  1  exception/interrupt taken this cycle; cancels E-stage op.
REQ-010 stall  out  1  freeze F/D/E pipeline registers.
REQ-011 busy  out  1  long operation in flight.
REQ-012 hi  out  32  architectural HI.
REQ-013 lo  out  32  architectural LO.
REQ-014 rd_data  out  32  mfhi/mflo result.
REQ-015 done  out  1  one-cycle pulse when HI/LO committed by a long op.

Function
REQ-016 FSM states SHALL be IDLE and BUSY; busy = (state == BUSY).
REQ-017 Issue SHALL occur at a rising edge when state IDLE, op_valid=1, op in 0..3, exc_int=0.
REQ-018 On issue: cnt <= MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); state <= BUSY; 64-bit result latched into internal tmp_hi/tmp_lo from rs_val/rt_val sampled at that edge.
REQ-019 mult: signed 32x32->64 product, {tmp_hi,tmp_lo}; multu: unsigned product.
REQ-020 div: tmp_lo = signed quotient truncated toward zero, tmp_hi = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-021 Divide by zero (div or divu): tmp_lo = 32'hFFFF_FFFF, tmp_hi = rs_val.
REQ-022 div of 32'h8000_0000 by 32'hFFFF_FFFF: tmp_lo = 32'h8000_0000, tmp_hi = 0.
REQ-023 In BUSY each edge SHALL decrement cnt; at the edge where cnt==1: hi <= tmp_hi, lo <= tmp_lo, state <= IDLE, done <= 1.
REQ-024 done SHALL be 1 for exactly the cycle after commit, else 0; busy therefore high exactly N cycles after issue.
REQ-025 hi/lo SHALL NOT change during BUSY except at commit.
REQ-026 mthi/mtlo SHALL write rs_val into hi/lo at the edge when IDLE, op_valid=1, exc_int=0; no state change.
REQ-027 rd_data SHALL be combinational: hi for op 6, lo for op 7, else 0.
REQ-028 stall SHALL be combinational: op_valid & busy, for any op 0..7; no stall when IDLE.
REQ-029 An op presented in the final BUSY cycle SHALL stall; it is accepted the following cycle (no back-to-back overlap).
REQ-030 exc_int SHALL block issue and mthi/mtlo in that cycle; an in-flight BUSY operation SHALL run to commit regardless of exc_int.
REQ-031 op_valid with op 0..3 and exc_int=1 while IDLE: no state change, stall=0.

Reset
REQ-032 reset=1 SHALL immediately (without clock) force state IDLE, cnt 0, hi 0, lo 0, tmp_hi 0, tmp_lo 0, done 0; thus busy 0, stall 0.
REQ-033 reset during BUSY SHALL abort the operation; no commit ever occurs for it.
REQ-034 First issue SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-035 mult rs=32'hFFFF_FFFE, rt=3 -> busy 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done pulse 1 cycle.
REQ-036 divu rs=7, rt=2 -> busy 10 cycles, then hi=1, lo=3; div rs=-7, rt=2 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFD.
REQ-037 div rs=5, rt=0 -> lo=32'hFFFF_FFFF, hi=5; div 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-038 mflo presented 2 cycles after mult issue -> stall=1 until busy drops, then rd_data = new lo.
REQ-039 mthi rs=32'h1234 with exc_int=1 -> hi unchanged; same with exc_int=0 -> hi=32'h1234.
REQ-040 reset pulse mid-div (cycle 4) -> busy, hi, lo = 0 asynchronously; no done pulse afterwards.
